// File: rtl/s2mm_rr_scheduler.sv
// Round-robin sharing of one DataMover S2MM channel (cmd/data/status) between two producers.
// Builds the 104-bit command at grant, forwards the granted stream, and turns status into done/err.
module s2mm_rr_scheduler #(
   parameter int ADDR_W      = 64,
   parameter int BTT_W       = 23,
   parameter int DATA_W      = 256,
   parameter int STS_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [BTT_W-1:0]  r0_btt,
   input  logic [DATA_W-1:0] r0_tdata,
   input  logic              r0_tvalid,
   input  logic              r0_tlast,
   output logic              r0_tready,
   output logic              r0_done,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [BTT_W-1:0]  r1_btt,
   input  logic [DATA_W-1:0] r1_tdata,
   input  logic              r1_tvalid,
   input  logic              r1_tlast,
   output logic              r1_tready,
   output logic              r1_done,
   output logic              r1_err,
   output logic [103:0]      s_axis_s2mm_cmd_tdata,
   output logic              s_axis_s2mm_cmd_tvalid,
   input  logic              s_axis_s2mm_cmd_tready,
   output logic [DATA_W-1:0] s_axis_s2mm_tdata,
   output logic              s_axis_s2mm_tvalid,
   output logic              s_axis_s2mm_tlast,
   input  logic              s_axis_s2mm_tready,
   input  logic [7:0]        m_axis_s2mm_sts_tdata,
   input  logic              m_axis_s2mm_sts_tvalid,
   output logic              m_axis_s2mm_sts_tready,
   output logic              grant
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_DATA = 3'd2,
      S_STS  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_nxt;
   logic              r_id;
   logic              r_last;
   logic              r_err;
   logic              r_sts_rdy;
   logic [103:0]      r_cmd;
   logic [9:0]        r_cnt;

   logic              w_req_any;
   logic              w_gnt_id;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic [BTT_W-1:0]  w_gnt_btt;
   logic              w_in_data;
   logic [DATA_W-1:0] w_tdata;
   logic              w_tvalid;
   logic              w_tlast;
   logic              w_last_hs;
   logic              w_sts_err;
   logic              w_sts_to;

   // r_last holds the previous winner; on a tie the other requester wins
   assign w_req_any  = r0_req | r1_req;
   assign w_gnt_id   = (r0_req & r1_req) ? ~r_last : r1_req;
   assign w_gnt_addr = w_gnt_id ? r1_addr : r0_addr;
   assign w_gnt_btt  = w_gnt_id ? r1_btt : r0_btt;

   assign w_in_data = (r_state == S_DATA);
   assign w_tdata   = r_id ? r1_tdata  : r0_tdata;
   assign w_tvalid  = r_id ? r1_tvalid : r0_tvalid;
   assign w_tlast   = r_id ? r1_tlast  : r0_tlast;
   assign w_last_hs = w_in_data & w_tvalid & s_axis_s2mm_tready & w_tlast;

   assign w_sts_err = ~m_axis_s2mm_sts_tdata[7] | m_axis_s2mm_sts_tdata[6] |
                      m_axis_s2mm_sts_tdata[5]  | m_axis_s2mm_sts_tdata[4] |
                      (m_axis_s2mm_sts_tdata[3:0] != {3'b000, r_id});
   assign w_sts_to  = (r_cnt == 10'(STS_TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) begin
               if (w_gnt_btt == '0) w_nxt = S_DONE;
               else                 w_nxt = S_CMD;
            end else begin
               w_nxt = S_IDLE;
            end
         end
         S_CMD: begin
            if (s_axis_s2mm_cmd_tready) w_nxt = S_DATA;
            else                        w_nxt = S_CMD;
         end
         S_DATA: begin
            if (w_last_hs) w_nxt = S_STS;
            else           w_nxt = S_DATA;
         end
         S_STS: begin
            if (m_axis_s2mm_sts_tvalid | w_sts_to) w_nxt = S_DONE;
            else                                   w_nxt = S_STS;
         end
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Grant capture, command build, status timeout counter and error latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id      <= 1'b0;
         r_last    <= 1'b1;
         r_err     <= 1'b0;
         r_cmd     <= 104'd0;
         r_cnt     <= 10'd0;
         r_sts_rdy <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 10'd0;
               if (w_req_any) begin
                  r_id <= w_gnt_id;
                  // zero-length requests are rejected without moving the pointer
                  if (w_gnt_btt == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err  <= 1'b0;
                     r_last <= w_gnt_id;
                     r_cmd  <= {4'h0, 3'b000, w_gnt_id, w_gnt_addr, 8'h40, 1'b1, w_gnt_btt};
                  end
               end
            end
            S_DATA: r_cnt <= 10'd0;
            S_STS: begin
               r_cnt <= r_cnt + 10'd1;
               if (m_axis_s2mm_sts_tvalid) r_err <= w_sts_err;
               else if (w_sts_to)          r_err <= 1'b1;
            end
            default: r_cnt <= 10'd0;
         endcase
         // stray status beats are drained everywhere except while a command is offered
         r_sts_rdy <= (w_nxt != S_CMD);
      end
   end

   assign s_axis_s2mm_cmd_tvalid = (r_state == S_CMD);
   assign s_axis_s2mm_cmd_tdata  = r_cmd;

   assign s_axis_s2mm_tdata  = w_in_data ? w_tdata : '0;
   assign s_axis_s2mm_tvalid = w_in_data & w_tvalid;
   assign s_axis_s2mm_tlast  = w_in_data & w_tlast;
   assign r0_tready          = w_in_data & ~r_id & s_axis_s2mm_tready;
   assign r1_tready          = w_in_data &  r_id & s_axis_s2mm_tready;

   assign r0_done = (r_state == S_DONE) & ~r_id;
   assign r1_done = (r_state == S_DONE) &  r_id;
   assign r0_err  = r0_done & r_err;
   assign r1_err  = r1_done & r_err;

   assign m_axis_s2mm_sts_tready = r_sts_rdy;
   assign grant                  = r_id;

endmodule

// File: tb/tb_s2mm_rr_scheduler.sv
// Randomized bench for s2mm_rr_scheduler: a transaction-level model predicts grant order,
// command word, forwarded beats, latency and done/err, and every comparison goes through check().
module tb_s2mm_rr_scheduler;

   localparam int STS_TO = 1023;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req;
   logic [63:0]  addr  [2];
   logic [22:0]  btt   [2];
   logic [255:0] tdata [2];
   logic [1:0]   tvalid, tlast, tready, done, err;
   logic [103:0] cmd_tdata;
   logic         cmd_tvalid, cmd_tready;
   logic [255:0] s_tdata;
   logic         s_tvalid, s_tlast, s_tready;
   logic [7:0]   sts_tdata;
   logic         sts_tvalid, sts_tready;
   logic         grant_o;

   bit           pend     [2];
   logic [63:0]  paddr    [2];
   logic [22:0]  pbtt     [2];
   bit           last_gnt;
   int           n_vec = 0;
   int           n_err = 0;

   s2mm_rr_scheduler #(.STS_TIMEOUT(STS_TO)) dut (
      .clk(clk), .rst(rst),
      .r0_req(req[0]), .r0_addr(addr[0]), .r0_btt(btt[0]), .r0_tdata(tdata[0]),
      .r0_tvalid(tvalid[0]), .r0_tlast(tlast[0]), .r0_tready(tready[0]),
      .r0_done(done[0]), .r0_err(err[0]),
      .r1_req(req[1]), .r1_addr(addr[1]), .r1_btt(btt[1]), .r1_tdata(tdata[1]),
      .r1_tvalid(tvalid[1]), .r1_tlast(tlast[1]), .r1_tready(tready[1]),
      .r1_done(done[1]), .r1_err(err[1]),
      .s_axis_s2mm_cmd_tdata(cmd_tdata), .s_axis_s2mm_cmd_tvalid(cmd_tvalid),
      .s_axis_s2mm_cmd_tready(cmd_tready),
      .s_axis_s2mm_tdata(s_tdata), .s_axis_s2mm_tvalid(s_tvalid),
      .s_axis_s2mm_tlast(s_tlast), .s_axis_s2mm_tready(s_tready),
      .m_axis_s2mm_sts_tdata(sts_tdata), .m_axis_s2mm_sts_tvalid(sts_tvalid),
      .m_axis_s2mm_sts_tready(sts_tready),
      .grant(grant_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {cmd_tvalid, s_tvalid, s_tlast, tready, done, err, sts_tready, grant_o}, 256'd0);
      check({tag, "_cmd"}, cmd_tdata, 256'd0);
      check({tag, "_data"}, s_tdata, 256'd0);
   endtask

   task automatic idle_inputs();
      req        = 2'b00;
      tvalid     = 2'b00;
      tlast      = 2'b00;
      tdata[0]   = '0;
      tdata[1]   = '0;
      cmd_tready = 1'b0;
      s_tready   = 1'b0;
      sts_tvalid = 1'b0;
      sts_tdata  = 8'h00;
   endtask

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // sts_kind: 0 = good status with matching tag, 1 = use sts_raw, 2 = never send status
   task automatic round(input int nbeats, input int stall, input int sts_kind,
                        input logic [7:0] sts_raw, input int sts_dly, input int abort_at);
      int           w, l, sent, got, cyc;
      logic [255:0] beats [$];
      logic [103:0] exp_cmd;
      logic [7:0]   sv;
      bit           pv, sr, early, exp_err;

      w = (pend[0] && pend[1]) ? (last_gnt ? 0 : 1) : (pend[1] ? 1 : 0);
      l = 1 - w;
      for (int i = 0; i < 2; i++) begin
         req[i]  = pend[i];
         addr[i] = paddr[i];
         btt[i]  = pbtt[i];
      end
      @(negedge clk);
      check("idle_cmd_tvalid", cmd_tvalid, 1'b0);
      check("idle_done", done, 2'b00);
      tick();

      if (pbtt[w] == 23'd0) begin
         req[w]  = 1'b0;
         pend[w] = 1'b0;
         @(negedge clk);
         check("zb_cmd_tvalid", cmd_tvalid, 1'b0);
         check("zb_done", done[w], 1'b1);
         check("zb_err", err[w], 1'b1);
         check("zb_other_done", done[l], 1'b0);
         check("zb_grant", grant_o, w[0]);
         tick();
         return;
      end

      last_gnt = w[0];
      exp_cmd  = {4'h0, 3'b000, w[0], paddr[w], 8'h40, 1'b1, pbtt[w]};
      for (int k = 0; k <= stall; k++) begin
         cmd_tready = (k == stall);
         if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
         @(negedge clk);
         check("cmd_tvalid", cmd_tvalid, 1'b1);
         check("cmd_tdata", cmd_tdata, exp_cmd);
         check("cmd_grant", grant_o, w[0]);
         check("cmd_sts_tready", sts_tready, 1'b0);
         check("cmd_tready_zero", tready, 2'b00);
         tick();
      end
      cmd_tready = 1'b0;

      for (int i = 0; i < nbeats; i++) beats.push_back(rnd256());
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < nbeats && cyc < 400) begin
         pv        = (sent < nbeats) && ($urandom_range(0, 3) != 0);
         tvalid[w] = pv;
         tdata[w]  = (sent < nbeats) ? beats[sent] : '0;
         tlast[w]  = (sent == nbeats - 1);
         tvalid[l] = 1'($urandom);
         tdata[l]  = rnd256();
         tlast[l]  = 1'($urandom);
         s_tready  = ($urandom_range(0, 2) != 0);
         sts_tvalid = ($urandom_range(0, 3) == 0);
         sts_tdata  = 8'($urandom);
         @(negedge clk);
         check("data_tvalid", s_tvalid, pv);
         check("data_own_tready", tready[w], s_tready);
         check("data_other_tready", tready[l], 1'b0);
         if (s_tvalid && s_tready) begin
            check("beat_data", s_tdata, beats[got]);
            check("beat_last", s_tlast, (got == nbeats - 1));
            got++;
         end
         if (pv && tready[w]) sent++;
         cyc++;
         tick();
         if (abort_at > 0 && got == abort_at) begin
            rst = 1'b1;
            #1;
            check_zero("abort");
            idle_inputs();
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            last_gnt = 1'b1;
            tick();
            @(negedge clk);
            check("abort_no_done", done, 2'b00);
            tick();
            return;
         end
      end
      check("data_beats", got, nbeats);
      tvalid     = 2'b00;
      tlast      = 2'b00;
      tdata[0]   = '0;
      tdata[1]   = '0;
      s_tready   = 1'b0;
      sts_tvalid = 1'b0;

      sv      = (sts_kind == 0) ? {4'h8, 3'b000, w[0]} : sts_raw;
      exp_err = (sts_kind == 2) ? 1'b1 : !((sv[7:4] == 4'h8) && (sv[3:0] == {3'b000, w[0]}));
      early   = 1'b0;
      for (int k = 0; k < STS_TO; k++) begin
         sr         = (sts_kind != 2) && (k == sts_dly);
         sts_tvalid = sr;
         sts_tdata  = sr ? sv : 8'($urandom);
         @(negedge clk);
         if (k == 0) begin
            check("sts_tready", sts_tready, 1'b1);
            check("sts_s_tvalid", s_tvalid, 1'b0);
         end
         if (done != 2'b00) early = 1'b1;
         tick();
         if (sr) break;
      end
      sts_tvalid = 1'b0;
      req[w]     = 1'b0;
      pend[w]    = 1'b0;
      check("early_done", early, 1'b0);
      @(negedge clk);
      check("done", done[w], 1'b1);
      check("done_err", err[w], exp_err);
      check("other_done", done[l], 1'b0);
      check("done_grant", grant_o, w[0]);
      tick();
   endtask

   task automatic post(input int id, input logic [63:0] a, input logic [22:0] b);
      pend[id]  = 1'b1;
      paddr[id] = a;
      pbtt[id]  = b;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      addr[0] = '0;
      addr[1] = '0;
      btt[0]  = '0;
      btt[1]  = '0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      last_gnt = 1'b1;
      #1 rst = 1'b1;
      #2 check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      tick();

      // single producer, 8 beats, OKAY status
      post(0, 64'h0A000000, 23'd256);
      round(8, 0, 0, 8'h00, 0, 0);
      // reset in the middle of a burst, then a clean r1 transfer
      post(0, {$urandom, $urandom}, 23'd128);
      round(6, 0, 0, 8'h00, 0, 3);
      post(1, {$urandom, $urandom}, 23'd64);
      round(4, 0, 0, 8'h00, 1, 0);
      // simultaneous requests over three back-to-back rounds
      post(0, {$urandom, $urandom}, 23'd64);
      post(1, {$urandom, $urandom}, 23'd64);
      round(2, 0, 0, 8'h00, 0, 0);
      post(0, {$urandom, $urandom}, 23'd64);
      round(2, 0, 0, 8'h00, 0, 0);
      post(1, {$urandom, $urandom}, 23'd64);
      round(2, 0, 0, 8'h00, 0, 0);
      // command stalled five cycles
      post(0, {$urandom, $urandom}, 23'd192);
      round(6, 5, 0, 8'h00, 2, 0);
      // SLVERR and tag mismatch
      post(0, {$urandom, $urandom}, 23'd32);
      round(4, 0, 1, 8'hC0, 0, 0);
      post(0, {$urandom, $urandom}, 23'd32);
      round(4, 0, 1, 8'h81, 0, 0);
      // status timeout, then zero-length request
      post(1, {$urandom, $urandom}, 23'd16);
      round(3, 0, 2, 8'h00, 0, 0);
      post(0, {$urandom, $urandom}, 23'd0);
      round(1, 0, 0, 8'h00, 0, 0);

      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1)
               post(i, {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom_range(1, 4096)));
         end
         if (!pend[0] && !pend[1]) post(0, {$urandom, $urandom}, 23'($urandom_range(1, 4096)));
         round($urandom_range(1, 6), $urandom_range(0, 3),
               (r % 12 == 7) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0),
               8'($urandom), $urandom_range(0, 4), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/s2mm_rr_scheduler.md
Name: s2mm_rr_scheduler

Overview:
- Shares one AXI DataMover S2MM channel (command, data and status streams) between two stream producers, e.g. two fibonacci/pattern generators.
- Arbitrates round-robin and builds the 104-bit S2MM command from the granted requester's address and byte count.
- Routes that requester's data stream until TLAST, then consumes the DataMover status and returns done/error to the requester.
- Sits between the producers and the DataMover S2MM slave ports.

Parameters:
ADDR_W, 64, destination address width (fixed by the 104-bit command format)
BTT_W, 23, bytes-to-transfer width
DATA_W, 256, stream data width
STS_TIMEOUT, 1023, cycles to wait for status before flagging an error (must be ≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rN_req  in  1  request; held high until rN_done (N = 0, 1, same set per requester)
rN_addr  in  ADDR_W  destination address, sampled at grant
rN_btt  in  BTT_W  byte count, sampled at grant
rN_tdata  in  DATA_W  producer data
rN_tvalid  in  1  producer valid
rN_tlast  in  1  producer last beat
rN_tready  out  1  ready back to producer
rN_done  out  1  one-cycle completion pulse
rN_err  out  1  error qualifier, valid with rN_done
s_axis_s2mm_cmd_tdata  out  104  command to DataMover
s_axis_s2mm_cmd_tvalid  out  1  command valid
s_axis_s2mm_cmd_tready  in  1  command ready
s_axis_s2mm_tdata  out  DATA_W  data to DataMover
s_axis_s2mm_tvalid  out  1  data valid
s_axis_s2mm_tlast  out  1  data last
s_axis_s2mm_tready  in  1  data ready
m_axis_s2mm_sts_tdata  in  8  status {OKAY, SLVERR, DECERR, INTERR, TAG[3:0]}
m_axis_s2mm_sts_tvalid  in  1  status valid
m_axis_s2mm_sts_tready  out  1  status ready
grant  out  1  id of the current/last granted requester

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0; cmd_tdata=0.
  - Round-robin pointer set so r0 wins the first simultaneous request.
  - Reset mid-transfer aborts immediately; no done is produced.
- States: IDLE, CMD, DATA, STS, DONE.
- IDLE:
  - If any rN_req is high, grant it. If both are high, grant the one not granted last.
  - Latch addr, btt and id.
  - If the latched btt==0, go to DONE with err=1 and issue no command. Otherwise go to CMD.
- CMD:
  - cmd_tvalid=1 from the first CMD cycle.
  - cmd_tdata={4'h0, 3'b0, id, addr, 8'h40, 1'b1, btt}, held stable while tvalid && !tready.
  - On cmd_tvalid && cmd_tready: clear tvalid the next cycle and go to DATA.
- DATA:
  - Combinational passthrough: s_axis tdata/tvalid/tlast = granted rN_*; granted rN_tready = s_axis_s2mm_tready.
  - Non-granted rN_tready=0. Outside DATA, all s_axis data outputs are 0 and all rN_tready are 0.
  - Beat count is not checked against btt.
  - On a beat with tvalid && tready && tlast, go to STS.
- STS:
  - sts_tready=1; a 10-bit counter increments each cycle.
  - On sts_tvalid: err = !sts[7] | sts[6] | sts[5] | sts[4] | (sts[3:0] != {3'b0, id}); go to DONE.
  - If the counter reaches STS_TIMEOUT with no status: err=1, go to DONE.
  - A status beat arriving in any other state is accepted and dropped: sts_tready=1 outside STS except in CMD.
- DONE:
  - Exactly one cycle; rN_done=1 for the granted id only, with rN_err; then return to IDLE.
  - The requester drops rN_req in the cycle it sees done.
  - The arbiter does not sample requests in DONE, so the minimum gap between grants is one IDLE cycle.
- Latency:
  - req high in IDLE → cmd_tvalid high on the next cycle.
  - Last-beat handshake → earliest done 2 cycles later (status on the first STS cycle).
- rN_req dropping after grant has no effect; the transfer completes.
- The pointer updates only at grant; it does not update for btt==0 rejections.

Test Plan:
1. r0 only, addr=0x0A000000, btt=256, 8 beats, tlast on beat 8, cmd_tready=1, status 0x80 → cmd_tdata={8'h00, 64'h0A000000, 8'h40, 1'b1, 23'd256}, 8 beats forwarded, r0_done with r0_err=0, r1_done never pulses.
2. r0 and r1 request in the same cycle, both with btt=64 → grant order r0, r1, r0 over three back-to-back rounds; command tag = id; a one-cycle IDLE gap between transfers.
3. s_axis_s2mm_tready toggled 1,0,0,1 mid-burst and cmd_tready held low for 5 cycles → no beat lost or duplicated; cmd_tdata stable throughout the stall.
4. Status 0xC0 (SLVERR), then a transfer with status 0x81 (tag mismatch) → r0_err=1 in both cases.
5. No status for STS_TIMEOUT cycles → rN_done with err=1 exactly STS_TIMEOUT cycles after entering STS; rN_btt=0 → done+err with no cmd_tvalid.
6. rst asserted during DATA at beat 3 → all outputs 0 asynchronously; after release, a new r1 request completes normally.
